// File: rtl/window_alignment_ctrl_pkg.sv
// Shared constants and types for the window-alignment store write path.
package pkg_windowAlignment;
  localparam int WORD_SIZE   = 32;
  localparam int WORDS       = 4;
  localparam int INDEX_WIDTH = 5;
  localparam int ADDR_WIDTH  = 2 * INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  typedef logic [WORDS-1:0][WORD_SIZE-1:0] block_t;
endpackage

// File: rtl/window_alignment_ctrl_if.sv
// Bundle of the cache stream and window-alignment write signals seen by the sequencer.
interface intf_windowAlignment #(
  parameter int WORD_SIZE   = 32,
  parameter int WORDS       = 4,
  parameter int INDEX_WIDTH = 5
);
  // Handshake: a word transfers on any rising edge where in_valid and in_ready are both high;
  // in_valid may drop at any time and in_data is only meaningful while in_valid is high.
  logic                              start;
  logic                              busy;
  logic                              done;
  logic                              in_valid;
  logic                              in_ready;
  logic [WORD_SIZE-1:0]              in_data;
  logic [INDEX_WIDTH-1:0]            waddrY;
  logic [INDEX_WIDTH-1:0]            waddrBlock;
  logic [WORDS-1:0][WORD_SIZE-1:0]   wdata;
  logic                              we;

  modport master (
    input  start, in_valid, in_data,
    output busy, done, in_ready, waddrY, waddrBlock, wdata, we
  );

  modport slave (
    output start, in_valid, in_data,
    input  busy, done, in_ready, waddrY, waddrBlock, wdata, we
  );
endinterface

// File: rtl/window_alignment_ctrl_packer.sv
// Packs WORDS consecutive accepted words into lanes and commits a full block to wdata.
module window_block_packer
  import pkg_windowAlignment::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int WORDS     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            accept_i,
  input  logic [WORD_SIZE-1:0]            data_i,
  output logic                            commit_o,
  output logic [WORDS-1:0][WORD_SIZE-1:0] wdata_o
);
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [WORDS-1:0][WORD_SIZE-1:0] lane_q, lane_d;
  logic [WORDS-1:0][WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                            last_lane;

  assign last_lane = (cnt_q == CW'(WORDS - 1));
  assign commit_o  = accept_i && last_lane;
  assign wdata_o   = wdata_q;

  // The committed block includes the word arriving this cycle, so commit from lane_d.
  always_comb begin
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    if (accept_i) begin
      lane_d[cnt_q] = data_i;
      if (last_lane) begin
        cnt_d   = '0;
        wdata_d = lane_d;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: rtl/window_alignment_ctrl.sv
// Write sequencer: fills one detection window with row-major block writes from the word stream.
module window_alignment_ctrl
  import pkg_windowAlignment::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int WORDS       = 4,
  parameter int INDEX_WIDTH = 5,
  parameter int ROW_BLOCKS  = 6,
  parameter int ROWS        = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_SIZE-1:0]            in_data,
  output logic [INDEX_WIDTH-1:0]          waddrY,
  output logic [INDEX_WIDTH-1:0]          waddrBlock,
  output logic [WORDS-1:0][WORD_SIZE-1:0] wdata,
  output logic                            we,
  output logic [1:0]                      dbg_state
);
  localparam int IW = INDEX_WIDTH;
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_LAST = LAST;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] blk_q, blk_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] waddr_y_q, waddr_blk_q;
  logic          we_q;
  logic          accept;
  logic          blk_done;
  logic          last_blk;

  assign in_ready   = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_LAST);
  assign done       = (state_q == ST_LAST);
  assign accept     = in_valid && in_ready;
  assign we         = we_q;
  assign waddrY     = waddr_y_q;
  assign waddrBlock = waddr_blk_q;
  assign dbg_state  = state_q;
  assign last_blk   = (row_q == IW'(ROWS - 1)) && (blk_q == IW'(ROW_BLOCKS - 1));

  window_block_packer #(
    .WORD_SIZE (WORD_SIZE),
    .WORDS     (WORDS)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept_i (accept),
    .data_i   (in_data),
    .commit_o (blk_done),
    .wdata_o  (wdata)
  );

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          blk_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (blk_done) begin
          if (last_blk) begin
            state_d = ST_LAST;
            blk_d   = '0;
            row_d   = '0;
          end else if (blk_q == IW'(ROW_BLOCKS - 1)) begin
            blk_d = '0;
            row_d = row_q + IW'(1);
          end else begin
            blk_d = blk_q + IW'(1);
          end
        end
      end
      ST_LAST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The write address is the index pair of the block that just completed, held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      row_q       <= '0;
      waddr_y_q   <= '0;
      waddr_blk_q <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      row_q   <= row_d;
      we_q    <= blk_done;
      if (blk_done) begin
        waddr_y_q   <= row_q;
        waddr_blk_q <= blk_q;
      end
    end
  end
endmodule

// File: tb/tb_window_alignment_ctrl.sv
// Randomized scoreboard bench for window_alignment_ctrl: nominal, stall, start spam, reset, corner.
`timescale 1ns/1ps
module tb_window_alignment_ctrl;
  localparam int WS    = 32;
  localparam int NW    = 4;
  localparam int IW    = 5;
  localparam int RB    = 3;
  localparam int NR    = 2;
  localparam int NBLK  = RB * NR;
  localparam int NWORD = NBLK * NW;
  localparam int DW    = NW * WS;
  localparam int EW    = 1 + 32 + IW + IW + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       m_rst_n, c_rst_n;
  logic [1:0] m_state, c_state;

  intf_windowAlignment #(.WORD_SIZE(WS), .WORDS(NW), .INDEX_WIDTH(IW)) m_if ();
  intf_windowAlignment #(.WORD_SIZE(WS), .WORDS(1),  .INDEX_WIDTH(IW)) c_if ();

  window_alignment_ctrl #(
    .WORD_SIZE(WS), .WORDS(NW), .INDEX_WIDTH(IW), .ROW_BLOCKS(RB), .ROWS(NR)
  ) u_dut (
    .clk(clk), .rst_n(m_rst_n), .start(m_if.start), .busy(m_if.busy), .done(m_if.done),
    .in_valid(m_if.in_valid), .in_ready(m_if.in_ready), .in_data(m_if.in_data),
    .waddrY(m_if.waddrY), .waddrBlock(m_if.waddrBlock), .wdata(m_if.wdata), .we(m_if.we),
    .dbg_state(m_state)
  );

  window_alignment_ctrl #(
    .WORD_SIZE(WS), .WORDS(1), .INDEX_WIDTH(IW), .ROW_BLOCKS(1), .ROWS(1)
  ) u_corner (
    .clk(clk), .rst_n(c_rst_n), .start(c_if.start), .busy(c_if.busy), .done(c_if.done),
    .in_valid(c_if.in_valid), .in_ready(c_if.in_ready), .in_data(c_if.in_data),
    .waddrY(c_if.waddrY), .waddrBlock(c_if.waddrBlock), .wdata(c_if.wdata), .we(c_if.we),
    .dbg_state(c_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: words of the current window, grouped into row-major blocks
  logic [WS-1:0] win_words[$];
  logic [EW-1:0] exp_q[$];
  int            wr_cnt;

  task automatic model_accept(input logic [WS-1:0] d, input int c);
    int            b;
    logic [DW-1:0] blk;
    logic [IW-1:0] r, k;
    win_words.push_back(d);
    if (win_words.size() % NW == 0) begin
      b = win_words.size() / NW - 1;
      for (int i = 0; i < NW; i++) blk[i*WS +: WS] = win_words[b*NW + i];
      r = IW'(b / RB);
      k = IW'(b % RB);
      exp_q.push_back({(b == NBLK - 1), 32'(c + 1), r, k, blk});
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (m_rst_n === 1'b1) begin
        if (m_if.we === 1'b1) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_we: got we=1 at row %0d blk %0d expected no write",
                     m_if.waddrY, m_if.waddrBlock);
          end else begin
            e = exp_q.pop_front();
            chk("waddrY", m_if.waddrY, e[DW+2*IW-1:DW+IW]);
            chk("waddrBlock", m_if.waddrBlock, e[DW+IW-1:DW]);
            chk("wdata", m_if.wdata, e[DW-1:0]);
            chk("we_cycle", cyc, e[DW+2*IW+31:DW+2*IW]);
            chk("done_with_we", m_if.done, e[EW-1]);
          end
        end else if (m_if.done === 1'b1) begin
          checks++;
          failures++;
          $display("FAIL done_without_we: got done=1 we=0 expected done only with we");
        end
      end
    end
  end

  // driver tasks
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, m_if.busy, 0);
    chk({tag, "_done"}, m_if.done, 0);
    chk({tag, "_in_ready"}, m_if.in_ready, 0);
    chk({tag, "_we"}, m_if.we, 0);
    chk({tag, "_waddrY"}, m_if.waddrY, 0);
    chk({tag, "_waddrBlock"}, m_if.waddrBlock, 0);
    chk({tag, "_wdata"}, m_if.wdata, 0);
    chk({tag, "_state"}, m_state, 0);
  endtask

  task automatic do_reset_mid();
    m_if.in_valid = 1'b0;
    m_if.start    = 1'b0;
    m_rst_n       = 1'b0;
    #1;
    exp_q.delete();
    win_words.delete();
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    m_rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_we_after_reset", m_if.we, 0);
    end
  endtask

  // vmode: 0 valid held high, 1 toggling, 2 random; abort_at >= 0 resets after that many words
  task automatic run_window(input int vmode, input bit spam, input int abort_at, input bit seq);
    int            acc, n, scyc;
    logic [WS-1:0] nxt;
    bit            tog;
    acc = 0; n = 0; nxt = '0; tog = 1'b1;
    win_words.delete();
    wr_cnt = 0;
    @(negedge clk);
    m_if.start    = 1'b1;
    m_if.in_valid = 1'b0;
    scyc          = cyc;
    while (acc < NWORD && n < 4000) begin
      @(negedge clk);
      n++;
      m_if.start = spam;
      if (abort_at >= 0 && acc == abort_at) begin
        do_reset_mid();
        return;
      end
      case (vmode)
        0:       m_if.in_valid = 1'b1;
        1:       m_if.in_valid = tog;
        default: m_if.in_valid = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      m_if.in_data = seq ? nxt : WS'($urandom);
      if (m_if.in_valid && m_if.in_ready) begin
        model_accept(m_if.in_data, cyc);
        acc++;
        nxt++;
      end
    end
    chk("words_accepted", acc, NWORD);
    n = 0;
    do begin
      @(negedge clk);
      m_if.start    = 1'b0;
      m_if.in_valid = 1'b0;
      n++;
    end while (m_if.done !== 1'b1 && n < 50);
    chk("done_seen", m_if.done, 1);
    chk("busy_in_last", m_if.busy, 1);
    chk("ready_low_in_last", m_if.in_ready, 0);
    if (vmode == 0) chk("start_to_done", cyc - scyc, 1 + NWORD);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("write_count", wr_cnt, NBLK);
  endtask

  task automatic corner_window();
    int            scyc, rdy, wes;
    logic [WS-1:0] d;
    rdy = 0; wes = 0;
    @(negedge clk);
    d             = WS'($urandom);
    c_if.start    = 1'b1;
    c_if.in_valid = 1'b1;
    c_if.in_data  = d;
    scyc          = cyc;
    repeat (4) begin
      @(negedge clk);
      c_if.start = 1'b0;
      if (c_if.in_ready === 1'b1) rdy++;
      if (c_if.we === 1'b1) begin
        wes++;
        chk("corner_done_with_we", c_if.done, 1);
        chk("corner_latency", cyc - scyc, 2);
        chk("corner_wdata", c_if.wdata, d);
        chk("corner_waddrY", c_if.waddrY, 0);
        chk("corner_waddrBlock", c_if.waddrBlock, 0);
      end
    end
    c_if.in_valid = 1'b0;
    chk("corner_ready_cycles", rdy, 1);
    chk("corner_we_count", wes, 1);
  endtask

  initial begin
    m_rst_n = 1'b0;
    c_rst_n = 1'b0;
    m_if.start = 1'b0; m_if.in_valid = 1'b0; m_if.in_data = '0;
    c_if.start = 1'b0; c_if.in_valid = 1'b0; c_if.in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("corner_reset_we", c_if.we, 0);
    chk("corner_reset_ready", c_if.in_ready, 0);
    chk("corner_reset_wdata", c_if.wdata, 0);
    m_rst_n = 1'b1;
    c_rst_n = 1'b1;
    @(negedge clk);

    run_window(0, 1'b0, -1, 1'b1);   // nominal sequential data
    run_window(1, 1'b0, -1, 1'b1);   // 1/0 stall pattern
    run_window(0, 1'b1, -1, 1'b1);   // start spammed during RUN
    run_window(0, 1'b0, 18, 1'b1);   // reset after 2 words of block (1,1)
    run_window(0, 1'b0, -1, 1'b1);   // fresh restart
    run_window(0, 1'b0, -1, 1'b0);   // back-to-back random windows
    run_window(0, 1'b0, -1, 1'b0);
    repeat (3) run_window(2, 1'($urandom_range(0, 1)), -1, 1'b0);

    corner_window();
    corner_window();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
